uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART transmitter that serializes one parallel word per frame onto `TX_OUT`: start bit, data LSB first, optional parity bit, then one stop bit. Each bit is held for `PRESCALE` clock cycles, matching the oversampling ratio the receiver's data sampler uses, so both ends share one clock and one prescale setting. It sits between the system-side data producer and the serial line, pairing with the UART receive path.

## Interface
- `DATA_WIDTH`, 8: width of the parallel data word.
- `PRESCALE_W`, 6: width of the `PRESCALE` input.
- `CLK` input 1: the single clock; all logic is on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `P_DATA` input `DATA_WIDTH`: word to transmit; sampled only on the accept cycle.
- `DATA_VALID` input 1: request to send `P_DATA`.
- `PAR_EN` input 1: 1 inserts a parity bit after the data bits.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd parity.
- `PRESCALE` input `PRESCALE_W`: number of clocks per bit. Legal values are 8, 16 and 32.
- `TX_OUT` output 1: serial line, registered, idles high.
- `BUSY` output 1: registered; high while a frame is in progress.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **Accept:** a request is accepted when the state is IDLE and `DATA_VALID`=1.
  - On that edge, latch `P_DATA`, `PAR_EN` and `PAR_TYP`.
  - Compute the parity bit from the latched data: `^data` for even, `~^data` for odd.
  - Move to START.
- **Requests while busy:** `DATA_VALID` outside IDLE is ignored. It is not queued, and the latched word is not altered.
- **Bit timing:** a bit counter runs from 0 to `PRESCALE`−1 within each bit. A bit ends when the counter reaches `PRESCALE`−1; the counter then wraps to 0.
- **Transitions:**
  - START→DATA after one bit.
  - DATA→DATA for `DATA_WIDTH` bits. A 3-bit index selects the bits LSB first.
  - After the last data bit, go DATA→PARITY if `PAR_EN`, otherwise DATA→STOP.
  - PARITY→STOP after one bit.
  - STOP→IDLE after one bit.
- **TX_OUT per state:** IDLE 1, START 0, DATA the indexed data bit, PARITY the parity bit, STOP 1.
- **BUSY:** 1 in every state except IDLE.
- **Input stability:** `PRESCALE` must be held constant while `BUSY`=1; behaviour if it changes is undefined. `PAR_EN` and `PAR_TYP` are taken from the latched copies, so changing them mid-frame has no effect.
- **Reset:** `RST`=1 at any time, including mid-frame, forces IDLE on the next edge.
  - Outputs: `TX_OUT`=1, `BUSY`=0.
  - Internals: counters and index cleared.
  - The frame in progress is abandoned, with no partial stop bit.

## Timing
- **Start of frame:** on the edge where a request is accepted, `TX_OUT` falls to 0 and `BUSY` rises to 1. Both outputs are registered and are decoded from the next state.
- **Frame length:** (2 + `DATA_WIDTH` + `PAR_EN`) × `PRESCALE` clocks.
  - 8N1 at `PRESCALE`=16 takes 160 clocks.
  - With parity it takes 176 clocks.
- **End of frame:** `BUSY` falls on the edge that ends the stop bit; `TX_OUT` stays 1.
- **Back-to-back frames:**
  - The earliest next accept is the first IDLE cycle, if `DATA_VALID` is already high then.
  - The line sees exactly one idle-high cycle between the stop bit and the next start bit, in addition to the full stop bit.
- **Bit boundaries:** every bit, including the first, is exactly `PRESCALE` cycles long.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `uart_tx_state_t`;
  - parity constants `PAR_EVEN`=0 and `PAR_ODD`=1;
  - the legal prescale constants 8, 16 and 32, shared with the receive path.
- One natural sub-module, `uart_tx_bit_timer`, owns:
  - the `PRESCALE` counter, producing a one-cycle `BIT_DONE` pulse;
  - the data bit index, producing a `LAST_DATA` flag.
- `uart_tx_frame` itself keeps the FSM, the data and parity registers, and the output mux.

## Test plan
- **8N1 frame:** reset, then `P_DATA`=0xA5, `PAR_EN`=0, `PRESCALE`=8 → `TX_OUT` reads 0, 1,0,1,0,0,1,0,1, 1 with every bit 8 clocks wide; `BUSY` is high for exactly 80 clocks.
- **Even parity:** `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, `PRESCALE`=16 → parity bit 0; frame is 176 clocks. Repeat with `PAR_TYP`=1 → parity bit 1.
- **Request while busy:** `P_DATA`=0x0F accepted; a request with `P_DATA`=0xFF is raised mid-frame → 0xFF is ignored; the line shows 0x0F only; `BUSY` timing is unchanged.
- **Back-to-back:** `DATA_VALID` held high with 0x3C then 0xC3, `PRESCALE`=32 → two complete frames separated by exactly one idle-high cycle after the stop bit.
- **Reset mid-frame:** `RST`=1 during data bit 3 → on the next edge `TX_OUT`=1 and `BUSY`=0; the next request produces a clean, complete frame.
- **Line reconstruction:** 256 random words with random parity settings and prescale values 8/16/32, sampled by a reference receiver model at mid-bit → every word and parity bit matches.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity selectors and the
// prescale ratios that both the transmit and receive paths agree on.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_X8  = 8;
    localparam int PRESCALE_X16 = 16;
    localparam int PRESCALE_X32 = 32;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit clock counter and LSB-first data bit index for the UART transmitter.
// BIT_IDX_NXT is exposed so the frame can register TX_OUT from the next state.
module uart_tx_bit_timer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int PRESCALE_W = 6,
    localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  RUN,
    input  logic                  DATA_PHASE,
    output logic                  BIT_DONE,
    output logic                  LAST_DATA,
    output logic [IDX_W-1:0]      BIT_IDX_NXT
);

    logic [PRESCALE_W-1:0] cnt;
    logic [IDX_W-1:0]      bit_idx;

    assign BIT_DONE  = RUN && (cnt == PRESCALE - 1'b1);
    assign LAST_DATA = (bit_idx == IDX_W'(DATA_WIDTH - 1));

    // Counter parks at zero while idle so the start bit gets a full PRESCALE.
    always_ff @(posedge CLK) begin
        if (RST || !RUN) begin
            cnt <= '0;
        end else if (BIT_DONE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        BIT_IDX_NXT = '0;
        if (DATA_PHASE) begin
            if (BIT_DONE) begin
                BIT_IDX_NXT = LAST_DATA ? '0 : bit_idx + 1'b1;
            end else begin
                BIT_IDX_NXT = bit_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_idx <= '0;
        end else begin
            bit_idx <= BIT_IDX_NXT;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// TX_OUT and BUSY are registered and decoded from the next FSM state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_tx_state_t        state;
    uart_tx_state_t        state_nxt;
    logic                  accept;
    logic                  bit_done;
    logic                  last_data;
    logic [IDX_W-1:0]      bit_idx_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_nxt;
    logic                  busy_nxt;
    logic                  tx_out_q;
    logic                  busy_q;

    assign accept = (state == ST_IDLE) && DATA_VALID;

    uart_tx_bit_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_bit_timer (
        .CLK         (CLK),
        .RST         (RST),
        .PRESCALE    (PRESCALE),
        .RUN         (state != ST_IDLE),
        .DATA_PHASE  (state == ST_DATA),
        .BIT_DONE    (bit_done),
        .LAST_DATA   (last_data),
        .BIT_IDX_NXT (bit_idx_nxt)
    );

    // Frame payload is captured once per accept; requests while busy never reach it.
    always_ff @(posedge CLK) begin
        if (accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_out_q <= tx_nxt;
            busy_q   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (DATA_VALID) state_nxt = ST_START;
            ST_START:  if (bit_done)   state_nxt = ST_DATA;
            ST_DATA:   if (bit_done && last_data) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_done)   state_nxt = ST_STOP;
            ST_STOP:   if (bit_done)   state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b1;
        case (state_nxt)
            ST_IDLE:   busy_nxt = 1'b0;
            ST_START:  tx_nxt   = 1'b0;
            ST_DATA:   tx_nxt   = data_q[bit_idx_nxt];
            ST_PARITY: tx_nxt   = par_bit_q;
            ST_STOP:   tx_nxt   = 1'b1;
            default: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_out_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and random bench for uart_tx_frame with a cycle-accurate line
// receiver fed from a scoreboard of accepted words.
module tb_uart_tx_frame;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        int         p;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic rx_en  = 1'b0;
    logic rx_act = 1'b0;

    uart_tx_frame #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic exp_t make_exp(input logic [7:0] d, input logic pe, input logic pt, input int p);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.pt   = pt;
        e.p    = p;
        return e;
    endfunction

    function automatic logic exp_parity(input exp_t e);
        return e.pt ? ~^e.data : ^e.data;
    endfunction

    // Expected line level for bit slot b of a frame (0 = start bit).
    function automatic logic line_bit(input exp_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (b == 9 && e.pe) return exp_parity(e);
        return 1'b1;
    endfunction

    initial begin : rx_model
        exp_t       cur;
        int         c;
        int         nb;
        int         b;
        int         ph;
        logic       prev;
        logic       line_ok;
        logic [7:0] rx_word;
        logic       rx_par;
        cur     = make_exp(8'h00, 1'b0, 1'b0, 8);
        prev    = 1'b1;
        c       = 0;
        nb      = 10;
        line_ok = 1'b1;
        rx_word = 8'h00;
        rx_par  = 1'b0;
        forever begin
            @(negedge CLK);
            if (!rx_en) begin
                rx_act = 1'b0;
                prev   = 1'b1;
            end else begin
                if (!rx_act && prev === 1'b1 && TX_OUT === 1'b0) begin
                    check("rx_frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        cur     = sb.pop_front();
                        rx_act  = 1'b1;
                        c       = 0;
                        nb      = 10 + int'(cur.pe);
                        line_ok = 1'b1;
                        rx_word = 8'h00;
                        rx_par  = 1'b0;
                    end
                end
                if (rx_act) begin
                    if (c < nb * cur.p) begin
                        b  = c / cur.p;
                        ph = c % cur.p;
                        if (TX_OUT !== line_bit(cur, b) || BUSY !== 1'b1) line_ok = 1'b0;
                        if (ph == cur.p / 2) begin
                            if (b >= 1 && b <= 8) rx_word[b-1] = TX_OUT;
                            else if (cur.pe && b == 9) rx_par = TX_OUT;
                        end
                        c++;
                    end else begin
                        check("rx_line", 32'(line_ok), 32'd1);
                        check("rx_word", 32'(rx_word), 32'(cur.data));
                        if (cur.pe) check("rx_parity", 32'(rx_par), 32'(exp_parity(cur)));
                        check("rx_idle_after_stop", 32'({BUSY, TX_OUT}), 32'd1);
                        rx_act = 1'b0;
                    end
                end
                prev = TX_OUT;
            end
        end
    end

    task automatic send_start(input logic [7:0] d, input logic pe, input logic pt, input int p, input bit push);
        @(negedge CLK);
        PRESCALE   = 6'(p);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        if (push) sb.push_back(make_exp(d, pe, pt, p));
        @(posedge CLK);
    endtask

    // Follows one frame from the cycle after its accept edge; returns BUSY width and mid-bit samples.
    task automatic run_frame(input int p, input bit keep, input logic [7:0] nxt, input int poke,
                             output int blen, output logic [11:0] bits);
        bit done;
        done = 1'b0;
        blen = 0;
        bits = '0;
        for (int k = 0; k < 40 * p + 10; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                if (keep) begin
                    P_DATA = nxt;
                    sb.push_back(make_exp(nxt, PAR_EN, PAR_TYP, p));
                end else begin
                    DATA_VALID = 1'b0;
                    PAR_EN     = 1'($urandom);
                    PAR_TYP    = 1'($urandom);
                end
            end
            if (poke > 0 && k == poke) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
            end
            if (poke > 0 && k == poke + 5) DATA_VALID = 1'b0;
            if (BUSY !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if ((blen % p) == p / 2 && (blen / p) < 12) bits[blen / p] = TX_OUT;
            blen++;
        end
        check("frame_timeout", 32'(done), 32'd1);
    endtask

    initial begin : stim
        int         blen;
        int         p;
        logic [11:0] bits;
        logic       pe;
        logic       seen_busy;

        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        PRESCALE   = 6'd8;
        repeat (3) @(negedge CLK);
        check("reset_tx", 32'(TX_OUT), 32'd1);
        check("reset_busy", 32'(BUSY), 32'd0);
        RST   = 1'b0;
        rx_en = 1'b1;
        repeat (2) @(negedge CLK);

        // 8N1, prescale 8
        send_start(8'hA5, 1'b0, 1'b0, 8, 1'b1);
        run_frame(8, 1'b0, 8'h00, 0, blen, bits);
        check("8n1_busy_len", 32'(blen), 32'd80);
        check("8n1_bits", 32'(bits[9:0]), 32'b1101001010);

        // Even and odd parity, prescale 16
        send_start(8'hA5, 1'b1, 1'b0, 16, 1'b1);
        run_frame(16, 1'b0, 8'h00, 0, blen, bits);
        check("even_busy_len", 32'(blen), 32'd176);
        check("even_parity_bit", 32'(bits[9]), 32'd0);
        check("even_stop_bit", 32'(bits[10]), 32'd1);
        send_start(8'hA5, 1'b1, 1'b1, 16, 1'b1);
        run_frame(16, 1'b0, 8'h00, 0, blen, bits);
        check("odd_busy_len", 32'(blen), 32'd176);
        check("odd_parity_bit", 32'(bits[9]), 32'd1);

        // Request raised mid-frame must be dropped
        send_start(8'h0F, 1'b0, 1'b0, 8, 1'b1);
        run_frame(8, 1'b0, 8'h00, 30, blen, bits);
        check("busy_req_len", 32'(blen), 32'd80);
        check("busy_req_word", 32'(bits[8:1]), 32'h0F);
        seen_busy = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) seen_busy = 1'b1;
        end
        check("busy_req_not_queued", 32'(seen_busy), 32'd0);

        // Back-to-back with DATA_VALID held high
        send_start(8'h3C, 1'b0, 1'b0, 32, 1'b1);
        run_frame(32, 1'b1, 8'hC3, 0, blen, bits);
        check("b2b_first_len", 32'(blen), 32'd320);
        check("b2b_first_word", 32'(bits[8:1]), 32'h3C);
        check("b2b_idle_level", 32'(TX_OUT), 32'd1);
        run_frame(32, 1'b0, 8'h00, 0, blen, bits);
        check("b2b_second_len", 32'(blen), 32'd320);
        check("b2b_second_start", 32'(bits[0]), 32'd0);
        check("b2b_second_word", 32'(bits[8:1]), 32'hC3);

        // Reset during data bit 3, then a clean frame
        repeat (3) @(negedge CLK);
        rx_en = 1'b0;
        send_start(8'h5A, 1'b0, 1'b0, 8, 1'b0);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (35) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset_tx", 32'(TX_OUT), 32'd1);
        check("midreset_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_reset_idle", 32'({BUSY, TX_OUT}), 32'd1);
        rx_en = 1'b1;
        send_start(8'h81, 1'b1, 1'b1, 16, 1'b1);
        run_frame(16, 1'b0, 8'h00, 0, blen, bits);
        check("post_reset_len", 32'(blen), 32'd176);
        check("post_reset_word", 32'(bits[8:1]), 32'h81);
        check("post_reset_parity", 32'(bits[9]), 32'd1);

        // Random words, parity settings and prescales
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pe = 1'($urandom);
            send_start(8'($urandom), pe, 1'($urandom), p, 1'b1);
            run_frame(p, 1'b0, 8'h00, 0, blen, bits);
            check("rand_busy_len", 32'(blen), 32'((10 + int'(pe)) * p));
        end

        for (int k = 0; k < 100 && (sb.size() != 0 || rx_act); k++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
